// File: rtl/jtag_master_pkg.sv
// Shared encodings and TMS patterns for the JTAG shift master.
// Each pattern is indexed by period number within its phase, so bit 0 is driven first.
package jtag_master_pkg;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_IR_HDR,
        ST_IR_SHIFT,
        ST_IR_TAIL,
        ST_DR_HDR,
        ST_DR_SHIFT,
        ST_DR_TAIL,
        ST_DONE
    } state_t;

    localparam int INIT_TLR_CYCLES = 5;

    // RTI -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam int         IR_HDR_LEN = 4;
    localparam logic [3:0] IR_HDR_TMS = 4'b0011;

    // RTI -> Select-DR -> Capture-DR -> Shift-DR
    localparam int         DR_HDR_LEN = 3;
    localparam logic [2:0] DR_HDR_TMS = 3'b001;

    // Exit1 -> Update -> RTI
    localparam int         TAIL_LEN = 2;
    localparam logic [1:0] TAIL_TMS = 2'b01;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/jtag_shift_master_tck_gen.sv
// TCK generator: CLK_DIV clk cycles low, CLK_DIV high; idle (tck=0) while en=0.
// rise_en/fall_en flag the cycle whose closing clk edge moves tck high/low.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tck,
    output logic fall_en,
    output logic rise_en
);

    localparam int             HW    = $clog2(CLK_DIV) + 1;
    localparam logic [HW-1:0]  HLAST = HW'(CLK_DIV - 1);

    logic [HW-1:0] hcnt;
    logic          half_last;

    assign half_last = en && (hcnt == HLAST);
    assign rise_en   = half_last && !tck;
    assign fall_en   = half_last && tck;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            tck  <= 1'b0;
        end else if (!en) begin
            hcnt <= '0;
            tck  <= 1'b0;
        end else if (hcnt == HLAST) begin
            hcnt <= '0;
            tck  <= ~tck;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

endmodule

// File: rtl/jtag_shift_master.sv
// JTAG TAP initiator: one IR scan then one DR scan per transaction, LSB first.
// Optional JTAG_SHIFT_MASTER_IR_CACHE_EN skips the IR scan when ir_in repeats.
module jtag_shift_master
    import jtag_master_pkg::*;
#(
    parameter int IRW     = 3,
    parameter int DW      = 2,
    parameter int CLK_DIV = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [IRW-1:0] ir_in,
    input  logic [DW-1:0]  dr_in,
    output logic           busy,
    output logic           done,
    output logic [DW-1:0]  dr_out,
    output logic           tck,
    output logic           tms,
    output logic           tdi,
    input  logic           tdo
);

    localparam int            BW        = $clog2(max3(IRW, DW, INIT_TLR_CYCLES)) + 1;
    localparam logic [BW-1:0] INIT_LAST = BW'(INIT_TLR_CYCLES);
    localparam logic [BW-1:0] IRH_LAST  = BW'(IR_HDR_LEN - 1);
    localparam logic [BW-1:0] IR_LAST   = BW'(IRW - 1);
    localparam logic [BW-1:0] DRH_LAST  = BW'(DR_HDR_LEN - 1);
    localparam logic [BW-1:0] DR_LAST   = BW'(DW - 1);
    localparam logic [BW-1:0] TAIL_LAST = BW'(TAIL_LEN - 1);

    state_t         state, state_nx;
    logic [BW-1:0]  bcnt;
    logic [IRW-1:0] ir_sr;
    logic [DW-1:0]  dr_sr;
    logic [DW-1:0]  cap;
    logic           tck_en, fall_en, rise_en;
    logic           accept, cache_hit;

    assign tck_en = (state != ST_IDLE) && (state != ST_DONE);
    assign accept = (state == ST_IDLE) && start;

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk     (clk),
        .reset   (reset),
        .en      (tck_en),
        .tck     (tck),
        .fall_en (fall_en),
        .rise_en (rise_en)
    );

`ifdef JTAG_SHIFT_MASTER_IR_CACHE_EN
    logic [IRW-1:0] ir_cache;
    logic           cache_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_cache  <= '0;
            cache_vld <= 1'b0;
        end else if (accept) begin
            ir_cache  <= ir_in;
            cache_vld <= 1'b1;
        end
    end

    assign cache_hit = cache_vld && (ir_cache == ir_in);
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_INIT;
        else       state <= state_nx;
    end

    // Phases advance only at the end of a TCK period (the edge that drops tck).
    always_comb begin
        state_nx = state;
        case (state)
            ST_INIT:     if (fall_en && bcnt == INIT_LAST) state_nx = ST_IDLE;
            ST_IDLE:     if (start) state_nx = cache_hit ? ST_DR_HDR : ST_IR_HDR;
            ST_IR_HDR:   if (fall_en && bcnt == IRH_LAST)  state_nx = ST_IR_SHIFT;
            ST_IR_SHIFT: if (fall_en && bcnt == IR_LAST)   state_nx = ST_IR_TAIL;
            ST_IR_TAIL:  if (fall_en && bcnt == TAIL_LAST) state_nx = ST_DR_HDR;
            ST_DR_HDR:   if (fall_en && bcnt == DRH_LAST)  state_nx = ST_DR_SHIFT;
            ST_DR_SHIFT: if (fall_en && bcnt == DR_LAST)   state_nx = ST_DR_TAIL;
            ST_DR_TAIL:  if (fall_en && bcnt == TAIL_LAST) state_nx = ST_DONE;
            ST_DONE:     state_nx = ST_IDLE;
            default:     state_nx = ST_INIT;
        endcase
    end

    always_comb begin
        tms  = 1'b0;
        tdi  = 1'b0;
        busy = 1'b1;
        done = 1'b0;
        case (state)
            ST_INIT:     tms = (bcnt < INIT_LAST);
            ST_IDLE:     busy = 1'b0;
            ST_IR_HDR:   tms = IR_HDR_TMS[bcnt[1:0]];
            ST_IR_SHIFT: begin tms = (bcnt == IR_LAST); tdi = ir_sr[0]; end
            ST_IR_TAIL:  tms = TAIL_TMS[bcnt[0]];
            ST_DR_HDR:   tms = DR_HDR_TMS[bcnt[1:0]];
            ST_DR_SHIFT: begin tms = (bcnt == DR_LAST); tdi = dr_sr[0]; end
            ST_DR_TAIL:  tms = TAIL_TMS[bcnt[0]];
            ST_DONE:     begin busy = 1'b0; done = 1'b1; end
            default:     tms = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt   <= '0;
            ir_sr  <= '0;
            dr_sr  <= '0;
            cap    <= '0;
            dr_out <= '0;
        end else begin
            if (state_nx != state) bcnt <= '0;
            else if (fall_en)      bcnt <= bcnt + 1'b1;

            if (accept) begin
                ir_sr <= ir_in;
                dr_sr <= dr_in;
            end else if (fall_en && state == ST_IR_SHIFT) begin
                ir_sr <= ir_sr >> 1;
            end else if (fall_en && state == ST_DR_SHIFT) begin
                dr_sr <= dr_sr >> 1;
            end

            // First bit sampled ends up in the LSB after DW right shifts.
            if (rise_en && state == ST_DR_SHIFT)
                cap <= (cap >> 1) | (DW'(tdo) << (DW - 1));

            if (state == ST_DR_TAIL && state_nx == ST_DONE)
                dr_out <= cap;
        end
    end

endmodule

// File: tb/tb_jtag_shift_master.sv
// Directed bench for jtag_shift_master with a behavioural TAP target holding a
// 2-bit status register at IR 3'b001 (all other IRs select a 1-bit bypass).
module tb_jtag_shift_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] ir_in = '0;
    logic [1:0] dr_in = '0;
    logic       busy, done, tck, tms, tdi;
    logic [1:0] dr_out;
    logic       tdo = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jtag_shift_master #(.IRW(3), .DW(2), .CLK_DIV(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .ir_in  (ir_in),
        .dr_in  (dr_in),
        .busy   (busy),
        .done   (done),
        .dr_out (dr_out),
        .tck    (tck),
        .tms    (tms),
        .tdi    (tdi),
        .tdo    (tdo)
    );

    // Target TAP; its controller shares the system reset, data registers do not.
    typedef enum logic [3:0] {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                              SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
    tap_t       ts = TLR;
    logic [2:0] t_ir = 3'b000, t_irsh = 3'b000;
    logic [1:0] t_st = 2'b00, t_drsh = 2'b00;
    logic       t_byp = 1'b0;
    int         rises = 0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:  return m ? TLR  : RTI;
            RTI:  return m ? SDR  : RTI;
            SDR:  return m ? SIR  : CDR;
            CDR:  return m ? E1DR : SHDR;
            SHDR: return m ? E1DR : SHDR;
            E1DR: return m ? UDR  : PDR;
            PDR:  return m ? E2DR : PDR;
            E2DR: return m ? UDR  : SHDR;
            UDR:  return m ? SDR  : RTI;
            SIR:  return m ? TLR  : CIR;
            CIR:  return m ? E1IR : SHIR;
            SHIR: return m ? E1IR : SHIR;
            E1IR: return m ? UIR  : PIR;
            PIR:  return m ? E2IR : PIR;
            E2IR: return m ? UIR  : SHIR;
            UIR:  return m ? SDR  : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge tck or posedge reset) begin
        if (reset) begin
            ts   <= TLR;
            t_ir <= 3'b000;
        end else begin
            case (ts)
                TLR:  t_ir <= 3'b000;
                CDR:  if (t_ir == 3'b001) t_drsh <= t_st; else t_byp <= 1'b0;
                SHDR: if (t_ir == 3'b001) t_drsh <= {tdi, t_drsh[1]}; else t_byp <= tdi;
                UDR:  if (t_ir == 3'b001) t_st <= t_drsh;
                CIR:  t_irsh <= 3'b001;
                SHIR: t_irsh <= {tdi, t_irsh[2:1]};
                UIR:  t_ir <= t_irsh;
                default: ;
            endcase
            ts    <= tap_next(ts, tms);
            rises <= rises + 1;
        end
    end

    always @(negedge tck or posedge reset) begin
        if (reset) tdo <= 1'b0;
        else if (ts == SHDR) tdo <= (t_ir == 3'b001) ? t_drsh[0] : t_byp;
        else if (ts == SHIR) tdo <= t_irsh[0];
        else tdo <= 1'b0;
    end

`ifdef JTAG_SHIFT_MASTER_IR_CACHE_EN
    logic       c_vld = 1'b0;
    logic [2:0] c_ir  = 3'b000;
`endif

    // Expected TCK periods for the next transaction (IRW+DW+11, or DW+5 on a cache hit).
    task automatic model_periods(input logic [2:0] ir, output int p);
`ifdef JTAG_SHIFT_MASTER_IR_CACHE_EN
        p = (c_vld && c_ir == ir) ? 7 : 16;
        c_vld = 1'b1;
        c_ir  = ir;
`else
        p = 16;
`endif
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (busy || done); i++) @(negedge clk);
    endtask

    task automatic run_txn(input logic [2:0] ir, input logic [1:0] dr, output int periods,
                           output int cycles, output logic [1:0] got, output bit timeout);
        int r0;
        wait_idle();
        ir_in = ir; dr_in = dr; start = 1'b1;
        @(posedge clk);
        r0 = rises;
        #1 start = 1'b0;
        timeout = 1'b1; cycles = 0; got = 2'bxx;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (done) begin cycles = k; got = dr_out; timeout = 1'b0; break; end
        end
        periods = rises - r0;
    endtask

    task automatic test_reset();
        int k, nr;
        logic [5:0] th;
        logic pt;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (tck !== 1'b0)  begin n_fail++; $display("FAIL rst_tck got %b want 0", tck); end
        n_tests++; if (tms !== 1'b1)  begin n_fail++; $display("FAIL rst_tms got %b want 1", tms); end
        n_tests++; if (tdi !== 1'b0)  begin n_fail++; $display("FAIL rst_tdi got %b want 0", tdi); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy got %b want 1", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
        n_tests++; if (dr_out !== 2'b00) begin n_fail++; $display("FAIL rst_dr_out got %b want 00", dr_out); end
        @(negedge clk); reset = 1'b0;
        k = 0; nr = 0; th = '0; pt = tck;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (tck && !pt) begin nr++; th = {th[4:0], tms}; end
            pt = tck;
            if (!busy) begin k = i; break; end
        end
        n_tests++; if (k != 24) begin n_fail++; $display("FAIL init_cycles got %0d want 24", k); end
        n_tests++; if (nr != 6) begin n_fail++; $display("FAIL init_periods got %0d want 6", nr); end
        n_tests++; if (th !== 6'b111110) begin n_fail++; $display("FAIL init_tms_seq got %b want 111110", th); end
        n_tests++; if (tck !== 1'b0 || tms !== 1'b0) begin n_fail++; $display("FAIL idle_pins got tck=%b tms=%b want 0/0", tck, tms); end
    endtask

    task automatic test_status_rw();
        int p, ep, c; logic [1:0] got; bit to;
        model_periods(3'b001, ep);
        run_txn(3'b001, 2'b10, p, c, got, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL t1_timeout got no done want done"); end
        n_tests++; if (p != ep) begin n_fail++; $display("FAIL t1_periods got %0d want %0d", p, ep); end
        n_tests++; if (c != ep * 4) begin n_fail++; $display("FAIL t1_cycles got %0d want %0d", c, ep * 4); end
        n_tests++; if (got !== 2'b00) begin n_fail++; $display("FAIL t1_dr_out got %b want 00", got); end
        n_tests++; if (t_st !== 2'b10) begin n_fail++; $display("FAIL t1_status got %b want 10", t_st); end
        @(posedge clk); #1;
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL t1_done_width got %b want 0", done); end
        model_periods(3'b001, ep);
        run_txn(3'b001, 2'b01, p, c, got, to);
        n_tests++; if (p != ep) begin n_fail++; $display("FAIL t2_periods got %0d want %0d", p, ep); end
        n_tests++; if (got !== 2'b10) begin n_fail++; $display("FAIL t2_dr_out got %b want 10", got); end
        n_tests++; if (t_st !== 2'b01) begin n_fail++; $display("FAIL t2_status got %b want 01", t_st); end
    endtask

    task automatic test_bypass();
        int p, ep, c; logic [1:0] got; bit to;
        model_periods(3'b000, ep);
        run_txn(3'b000, 2'b11, p, c, got, to);
        n_tests++; if (p != ep) begin n_fail++; $display("FAIL byp_periods got %0d want %0d", p, ep); end
        n_tests++; if (got !== 2'b10) begin n_fail++; $display("FAIL byp_dr_out got %b want 10", got); end
        n_tests++; if (t_st !== 2'b01) begin n_fail++; $display("FAIL byp_status got %b want 01", t_st); end
    endtask

    task automatic test_start_during_busy();
        int ep, ndone; logic sb;
        wait_idle();
        ir_in = 3'b001; dr_in = 2'b01; start = 1'b1;
        model_periods(3'b001, ep);
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        sb = busy; start = 1'b1;
        @(negedge clk); start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 160; i++) begin @(posedge clk); #1; if (done) ndone++; end
        n_tests++; if (sb !== 1'b1) begin n_fail++; $display("FAIL busy_at_repulse got %b want 1", sb); end
        n_tests++; if (ndone != 1) begin n_fail++; $display("FAIL done_count got %0d want 1", ndone); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int ep; logic [1:0] got1, got2; bit to1, to2;
        wait_idle();
        ir_in = 3'b001; dr_in = 2'b10; start = 1'b1;
        model_periods(3'b001, ep);
        to1 = 1'b1; got1 = 2'bxx;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (done) begin to1 = 1'b0; got1 = dr_out; break; end
        end
        n_tests++; if (to1 || got1 !== 2'b01) begin n_fail++; $display("FAIL b2b_first got %b (to=%0d) want 01", got1, to1); end
        n_tests++; if (t_st !== 2'b10) begin n_fail++; $display("FAIL b2b_status1 got %b want 10", t_st); end
        @(posedge clk); #1;
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got busy=%b done=%b want 0/0", busy, done); end
        @(posedge clk); #1;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_retrigger got busy=%b want 1", busy); end
        model_periods(3'b001, ep);
        @(negedge clk); start = 1'b0;
        to2 = 1'b1; got2 = 2'bxx;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (done) begin to2 = 1'b0; got2 = dr_out; break; end
        end
        n_tests++; if (to2 || got2 !== 2'b10) begin n_fail++; $display("FAIL b2b_second got %b (to=%0d) want 10", got2, to2); end
    endtask

    task automatic test_reset_mid();
        int ep, r0, k; bit ok;
        wait_idle();
        ir_in = 3'b001; dr_in = 2'b11; start = 1'b1;
        model_periods(3'b001, ep);
        @(posedge clk);
        r0 = rises;
        #1 start = 1'b0;
        ok = 1'b0;
        // first DR shift period is the (ep-3)th TCK period of the transaction
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (tck && (rises - r0) == ep - 3) begin ok = 1'b1; break; end
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL mid_reach_dr_shift got none want tck high in DR shift"); end
        #2 reset = 1'b1;
        #1;
        n_tests++; if (tck !== 1'b0 || tms !== 1'b1) begin n_fail++; $display("FAIL mid_reset_pins got tck=%b tms=%b want 0/1", tck, tms); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_reset_busy got %b want 1", busy); end
`ifdef JTAG_SHIFT_MASTER_IR_CACHE_EN
        c_vld = 1'b0;
`endif
        @(negedge clk); reset = 1'b0;
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (!busy) begin k = i; break; end
        end
        n_tests++; if (k != 24) begin n_fail++; $display("FAIL mid_init_cycles got %0d want 24", k); end
        n_tests++; if (dr_out !== 2'b00) begin n_fail++; $display("FAIL mid_dr_out got %b want 00", dr_out); end
        n_tests++; if (t_st !== 2'b10) begin n_fail++; $display("FAIL mid_status got %b want 10", t_st); end
    endtask

    task automatic test_ir_cache();
        logic [2:0] irs [4] = '{3'b001, 3'b001, 3'b000, 3'b001};
`ifdef JTAG_SHIFT_MASTER_IR_CACHE_EN
        int exp_p [4] = '{16, 7, 16, 16};
`else
        int exp_p [4] = '{16, 16, 16, 16};
`endif
        int p, c; logic [1:0] got; bit to;
        for (int j = 0; j < 4; j++) begin
            if (j == 3) begin
                @(negedge clk); reset = 1'b1;
                @(negedge clk); reset = 1'b0;
            end
            run_txn(irs[j], 2'b00, p, c, got, to);
            n_tests++; if (to || p != exp_p[j]) begin n_fail++; $display("FAIL cache_periods[%0d] got %0d (to=%0d) want %0d", j, p, to, exp_p[j]); end
            n_tests++; if (c != exp_p[j] * 4) begin n_fail++; $display("FAIL cache_cycles[%0d] got %0d want %0d", j, c, exp_p[j] * 4); end
        end
    endtask

    initial begin
        test_reset();
        test_status_rw();
        test_bypass();
        test_start_during_busy();
        test_back_to_back();
        test_reset_mid();
        test_ir_cache();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish want finish within 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
